// File: rtl/parity_stream_unit.sv
// Bit-serial parity generator/checker: appends a parity bit to each DATA_BITS frame,
// or strips and verifies it, behind a single-entry output register with valid/ready.
module parity_stream_unit #(
  parameter int DATA_BITS = 8,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode_odd,
  input  logic             mode_check,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_bit,
  output logic             out_last,
  output logic             err,
  output logic [CNT_W-1:0] err_count
);

  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [1:0] {
    ST_DATA = 2'd0,
    ST_PAR  = 2'd1,
    ST_CHK  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [IDX_W-1:0] r_idx;
  logic             r_acc;
  logic             r_mo;
  logic             r_mc;

  logic w_free;
  logic w_first;
  logic w_last;
  logic w_mc_eff;
  logic w_load_data;
  logic w_load_par;
  logic w_chk_xfer;
  logic w_mismatch;

  assign w_free     = !out_valid || out_ready;
  assign w_first    = (r_idx == '0);
  assign w_last     = (r_idx == IDX_W'(DATA_BITS - 1));
  // The first bit of a frame must already obey the mode it is latching.
  assign w_mc_eff   = w_first ? mode_check : r_mc;
  assign w_mismatch = (r_acc ^ in_bit) != r_mo;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_DATA;
    else       r_state <= w_state_next;
  end

  // NOTE: every always_comb output gets a default first, otherwise a path that
  // skips an assignment infers a latch.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    w_load_data  = 1'b0;
    w_load_par   = 1'b0;
    w_chk_xfer   = 1'b0;
    case (r_state)
      ST_DATA: begin
        in_ready = w_free;
        if (in_valid && w_free) begin
          w_load_data = 1'b1;
          if (w_last) w_state_next = w_mc_eff ? ST_CHK : ST_PAR;
        end
      end
      ST_PAR: begin
        if (w_free) begin
          w_load_par   = 1'b1;
          w_state_next = ST_DATA;
        end
      end
      ST_CHK: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_chk_xfer   = 1'b1;
          w_state_next = ST_DATA;
        end
      end
      default: w_state_next = ST_DATA;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      out_last  <= 1'b0;
      err       <= 1'b0;
      err_count <= '0;
      r_idx     <= '0;
      r_acc     <= 1'b0;
      r_mo      <= 1'b0;
      r_mc      <= 1'b0;
    end else begin
      err <= 1'b0;

      if (w_load_data) begin
        out_bit   <= in_bit;
        out_last  <= w_last && w_mc_eff;
        out_valid <= 1'b1;
        r_acc     <= r_acc ^ in_bit;
        r_idx     <= w_last ? '0 : r_idx + IDX_W'(1);
        if (w_first) begin
          r_mo <= mode_odd;
          r_mc <= mode_check;
        end
      end else if (w_load_par) begin
        out_bit   <= r_acc ^ r_mo;
        out_last  <= 1'b1;
        out_valid <= 1'b1;
        r_acc     <= 1'b0;
      end else if (w_free) begin
        out_valid <= 1'b0;
      end

      if (w_chk_xfer) begin
        err   <= w_mismatch;
        r_acc <= 1'b0;
        if (w_mismatch && (err_count != {CNT_W{1'b1}}))
          err_count <= err_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_parity_stream_unit.sv
// Self-checking bench: frame-level parity model with a queue of expected output bits,
// randomized handshakes/modes, plus CNT_W=2 and DATA_BITS=1 instances.
module tb_parity_stream_unit;

  localparam int DB = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, mode_odd, mode_check, in_valid, in_bit, out_ready;
  logic in_ready, out_valid, out_bit, out_last, err;
  logic [7:0] err_count;
  logic b_in_ready, b_out_valid, b_out_bit, b_out_last, b_err;
  logic [1:0] b_err_count;
  logic c_mode_odd, c_mode_check, c_in_valid, c_in_bit, c_out_ready;
  logic c_in_ready, c_out_valid, c_out_bit, c_out_last, c_err;
  logic [7:0] c_err_count;

  parity_stream_unit #(.DATA_BITS(DB), .CNT_W(8)) u_dut (
    .clk(clk), .reset(reset), .mode_odd(mode_odd), .mode_check(mode_check),
    .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit),
    .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit),
    .out_last(out_last), .err(err), .err_count(err_count));

  parity_stream_unit #(.DATA_BITS(DB), .CNT_W(2)) u_dut_sat (
    .clk(clk), .reset(reset), .mode_odd(mode_odd), .mode_check(mode_check),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_bit(in_bit),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_bit(b_out_bit),
    .out_last(b_out_last), .err(b_err), .err_count(b_err_count));

  parity_stream_unit #(.DATA_BITS(1), .CNT_W(8)) u_dut_one (
    .clk(clk), .reset(reset), .mode_odd(c_mode_odd), .mode_check(c_mode_check),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_bit(c_in_bit),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_bit(c_out_bit),
    .out_last(c_out_last), .err(c_err), .err_count(c_err_count));

  typedef struct packed {logic b; logic last;} obit_t;

  int    vectors     = 0;
  int    miscompares = 0;
  obit_t exp_q[$];
  int    err_total   = 0;
  logic  cur_is_par  = 1'b0;
  logic  cur_bad     = 1'b0;
  logic  sending_data = 1'b0;
  logic  accepted    = 1'b0;
  logic  held_valid  = 1'b0;
  obit_t held;
  int    rdy_pct     = 100;
  int    force_stall = 0;

  function automatic int sat(int v, int m);
    return (v > m) ? m : v;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: sample outputs on the falling edge, check err/err_count after the rising edge.
  task automatic tick();
    obit_t e;
    logic  par_x;
    @(negedge clk);
    accepted = in_valid && in_ready;
    par_x    = accepted && cur_is_par;
    if (sending_data && in_valid && out_valid && !out_ready)
      check("in_ready_stall", {31'd0, in_ready}, 32'd0);
    if (held_valid) begin
      check("held_valid", {31'd0, out_valid}, 32'd1);
      check("held_bit",   {31'd0, out_bit},   {31'd0, held.b});
      check("held_last",  {31'd0, out_last},  {31'd0, held.last});
    end
    held_valid = out_valid && !out_ready;
    held       = '{b: out_bit, last: out_last};
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("out_bit",  {31'd0, out_bit},  {31'd0, e.b});
        check("out_last", {31'd0, out_last}, {31'd0, e.last});
      end
    end
    @(posedge clk);
    #1;
    if (par_x && cur_bad) err_total++;
    check("err", {31'd0, err}, {31'd0, par_x && cur_bad});
    check("err_count", {24'd0, err_count}, 32'(sat(err_total, 255)));
    check("err_count_sat", {30'd0, b_err_count}, 32'(sat(err_total, 3)));
  endtask

  task automatic send_bit(logic b, logic om, logic cm, logic is_par, logic bad);
    int n = 0;
    in_valid = 1'b1; in_bit = b; mode_odd = om; mode_check = cm;
    cur_is_par = is_par; cur_bad = bad; sending_data = !is_par;
    accepted = 1'b0;
    while (!accepted && n < 200) begin
      if (force_stall > 0) begin
        out_ready = 1'b0;
        force_stall--;
      end else begin
        out_ready = ($urandom_range(99) < rdy_pct);
      end
      tick();
      n++;
    end
    if (!accepted) check("accept_timeout", 32'd1, 32'd0);
    in_valid = 1'b0; sending_data = 1'b0; cur_is_par = 1'b0; cur_bad = 1'b0;
    if (rdy_pct < 100 && $urandom_range(3) == 0) begin
      out_ready = 1'($urandom_range(1));
      tick();
    end
  endtask

  task automatic idle(int n, logic rdy);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      out_ready = rdy;
      tick();
    end
  endtask

  // data[i] is the i-th bit on the wire; modes on later bits are scrambled on purpose.
  task automatic send_frame(logic [DB-1:0] data, logic odd, logic chk, logic bad, int stall_at);
    logic p;
    p = logic'($countones(data) % 2) ^ odd;
    for (int i = 0; i < DB; i++) exp_q.push_back('{b: data[i], last: chk && (i == DB - 1)});
    if (!chk) exp_q.push_back('{b: p, last: 1'b1});
    for (int i = 0; i < DB; i++) begin
      if (i == stall_at) force_stall = 5;
      if (i == 0) send_bit(data[i], odd, chk, 1'b0, 1'b0);
      else        send_bit(data[i], 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0, 1'b0);
    end
    if (!chk) check("in_ready_par", {31'd0, in_ready}, 32'd0);
    if (chk) send_bit(bad ? ~p : p, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b1, bad);
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    while ((exp_q.size() > 0 || out_valid) && n < 100) begin
      out_ready = 1'b1;
      tick();
      n++;
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete(); err_total = 0; held_valid = 1'b0;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_bit",   {31'd0, out_bit},   32'd0);
    check("rst_out_last",  {31'd0, out_last},  32'd0);
    check("rst_err",       {31'd0, err},       32'd0);
    check("rst_err_count", {24'd0, err_count}, 32'd0);
    check("rst_cnt_sat",   {30'd0, b_err_count}, 32'd0);
    check("rst_c_valid",   {31'd0, c_out_valid}, 32'd0);
  endtask

  // DATA_BITS=1 stream: {bit, odd, check, is_parity, bad}
  obit_t c_exp[$];
  obit_t c_got[$];

  task automatic c_send(logic b, logic om, logic cm, logic is_par, logic bad);
    int   n = 0;
    logic acc = 1'b0;
    c_in_valid = 1'b1; c_in_bit = b; c_mode_odd = om; c_mode_check = cm; c_out_ready = 1'b1;
    while (!acc && n < 50) begin
      @(negedge clk);
      if (c_out_valid && c_out_ready) c_got.push_back('{b: c_out_bit, last: c_out_last});
      acc = c_in_valid && c_in_ready;
      @(posedge clk);
      #1;
      check("c_err", {31'd0, c_err}, {31'd0, acc && is_par && bad});
      n++;
    end
    if (!acc) check("c_accept_timeout", 32'd1, 32'd0);
    c_in_valid = 1'b0;
  endtask

  task automatic c_frame(logic d, logic odd, logic chk, logic bad);
    logic p;
    p = d ^ odd;
    c_exp.push_back('{b: d, last: chk});
    if (!chk) c_exp.push_back('{b: p, last: 1'b1});
    c_send(d, odd, chk, 1'b0, 1'b0);
    if (chk) c_send(bad ? ~p : p, 1'b0, 1'b0, 1'b1, bad);
  endtask

  initial begin
    reset = 1'b1; mode_odd = 1'b0; mode_check = 1'b0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b1;
    c_mode_odd = 1'b0; c_mode_check = 1'b0; c_in_valid = 1'b0; c_in_bit = 1'b0; c_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    do_reset();

    // Directed frames: stream 1,0,1,1,0,0,0,0 -> 8'b0000_1101 with bit 0 first.
    send_frame(8'b0000_1101, 1'b1, 1'b0, 1'b0, -1);
    send_frame(8'b0000_1101, 1'b0, 1'b0, 1'b0, -1);
    send_frame(8'hFF,        1'b1, 1'b0, 1'b0, -1);
    send_frame(8'b0000_1101, 1'b1, 1'b1, 1'b1, -1);
    send_frame(8'b0000_1101, 1'b1, 1'b1, 1'b0, -1);
    drain();

    // Backpressure mid-frame and across the parity bit.
    send_frame(8'b1010_0110, 1'b1, 1'b0, 1'b0, 4);
    idle(1, 1'b1);
    idle(5, 1'b0);
    send_frame(8'b0110_0011, 1'b0, 1'b1, 1'b1, 3);
    drain();

    // Randomized frames with random handshakes and scrambled mid-frame modes.
    rdy_pct = 70;
    for (int f = 0; f < 30; f++)
      send_frame(8'($urandom), 1'($urandom_range(1)), 1'($urandom_range(1)),
                 1'($urandom_range(1)), ($urandom_range(3) == 0) ? int'($urandom_range(DB - 1)) : -1);
    rdy_pct = 100;
    for (int f = 0; f < 5; f++) send_frame(8'($urandom), 1'b0, 1'b1, 1'b1, -1);
    drain();

    // Reset after 4 bits of a frame, then a clean frame from idx 0.
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{b: 1'b1, last: 1'b0});
      send_bit(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    do_reset();
    send_frame(8'b0011_0101, 1'b1, 1'b0, 1'b0, -1);
    send_frame(8'b0011_0101, 1'b0, 1'b1, 1'b1, -1);
    drain();
    for (int f = 0; f < 5; f++) send_frame(8'($urandom), 1'b1, 1'b1, 1'b1, -1);
    drain();

    // DATA_BITS=1 instance.
    c_frame(1'b1, 1'b1, 1'b0, 1'b0);
    c_frame(1'b0, 1'b1, 1'b0, 1'b0);
    c_frame(1'b1, 1'b0, 1'b0, 1'b0);
    c_frame(1'b1, 1'b1, 1'b1, 1'b1);
    c_frame(1'b0, 1'b1, 1'b1, 1'b0);
    c_frame(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (c_out_valid && c_out_ready) c_got.push_back('{b: c_out_bit, last: c_out_last});
    end
    check("c_count", 32'(c_got.size()), 32'(c_exp.size()));
    for (int i = 0; i < c_exp.size() && i < c_got.size(); i++) begin
      check("c_bit",  {31'd0, c_got[i].b},    {31'd0, c_exp[i].b});
      check("c_last", {31'd0, c_got[i].last}, {31'd0, c_exp[i].last});
    end
    check("c_err_count", {24'd0, c_err_count}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/parity_stream_unit.md
Name: parity_stream_unit

Overview:
- Parametrised bit-serial parity block for the serial datapath.
- Generate mode: appends one parity bit after every DATA_BITS-bit frame.
- Check mode: strips and verifies the parity bit of each (DATA_BITS+1)-bit frame.
- Odd/even selectable per frame; valid/ready handshake on both sides; saturating error counter.

Parameters:
- DATA_BITS, 8, data bits per frame (>=1).
- CNT_W, 8, width of err_count.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- mode_odd  in  1  1 = odd parity, 0 = even. Sampled at frame start.
- mode_check  in  1  1 = check, 0 = generate. Sampled at frame start.
- in_valid  in  1  input bit valid.
- in_ready  out  1  block can accept in_bit.
- in_bit  in  1  serial input, frame bits in arrival order.
- out_valid  out  1  out_bit valid.
- out_ready  in  1  downstream accepts out_bit.
- out_bit  out  1  serial output.
- out_last  out  1  marks the final output bit of a frame.
- err  out  1  one-cycle pulse on a check-mode parity mismatch.
- err_count  out  CNT_W  saturating count of mismatches.

Behaviour:
- Reset values:
  - out_valid=0, out_bit=0, out_last=0, err=0, err_count=0.
  - State DATA, idx=0, acc=0.
  - Reset takes priority over all events. A partial frame is discarded and the held output is dropped.
- Transfers:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - out_bit and out_last stay stable while out_valid=1 and out_ready=0.
- Output register: single entry, free = !out_valid | out_ready.
- Latency: an accepted data bit appears on out_bit the next cycle. There is no combinational in-to-out path.
- Per-frame state:
  - idx counts 0..DATA_BITS-1.
  - acc = XOR of accepted data bits.
  - mo/mc = mode_odd/mode_check, latched on the input transfer that has idx=0.
  - Mode changes mid-frame do not affect the current frame.
- State DATA:
  - in_ready = free.
  - On input transfer: load out_bit=in_bit, out_valid=1, acc^=in_bit, idx++.
  - out_last=1 only if this is the last data bit (idx=DATA_BITS-1) and mc=1.
  - On the last data bit: idx->0; go to PAR if mc=0, CHK if mc=1.
- State PAR (generate mode):
  - in_ready=0.
  - When free: load out_bit = acc ^ mo, out_last=1, out_valid=1.
  - Then acc->0 and go to DATA.
  - Resulting total ones (data + parity) is odd when mo=1, even when mo=0.
- State CHK (check mode):
  - in_ready=1; nothing is forwarded.
  - On input transfer: mismatch = (acc ^ in_bit) != mo.
  - err=mismatch on the next cycle, for one cycle.
  - err_count increments on mismatch and saturates at 2^CNT_W-1.
  - acc->0, go to DATA.
- Output register update: if free and nothing is loaded, out_valid->0.
- Simultaneous output transfer and new load in the same cycle is allowed: full throughput in DATA.
- Throughput in generate mode: DATA_BITS+1 output cycles per frame.
- DATA_BITS=1:
  - Every data bit is also the last data bit.
  - Generate mode alternates DATA and PAR.
  - Check mode emits out_last on every data bit.

Test Plan:
- Generate, odd, DATA_BITS=8, stream 1,0,1,1,0,0,0,0 with out_ready=1:
  - Outputs the 8 bits in order, then parity bit 0 with out_last=1.
  - in_ready=0 during the parity cycle. Total 9 outputs.
- Same stream, even: parity bit 1. Back-to-back second frame 8'hFF odd: parity 1.
- Check, odd, input 1,0,1,1,0,0,0,0 then parity 1:
  - 8 bits forwarded, out_last on the 8th.
  - err pulses one cycle after the parity bit is accepted; err_count=1.
  - A repeat with parity 0 gives no err.
- Backpressure: hold out_ready=0 for 5 cycles mid-frame and during the parity bit.
  - out_bit and out_last stay stable; in_ready=0; no bits are lost or duplicated.
- Mode toggled mid-frame: the frame completes in its latched mode. The next frame uses the new mode.
- Reset asserted after 4 bits:
  - Next frame starts at idx 0 with correct parity.
  - err_count=0.
  - With CNT_W=2 and 5 bad frames, err_count saturates at 3.
